// File: rtl/priority_scan_enc.sv
// Captures a hit vector and emits the index of each set bit, one per accepted beat, in priority order.
// Optional macro PRIORITY_SCAN_CNT_EN adds out_cnt (popcount of the captured vector).
module priority_scan_enc #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
`ifdef PRIORITY_SCAN_CNT_EN
    ,output logic [IDX_W:0]  out_cnt
`endif
);

    generate
        if (IDX_W != $clog2(WIDTH) || WIDTH < 2 || WIDTH > 256) begin : g_param_err
            $fatal(1, "priority_scan_enc: IDX_W must equal clog2(WIDTH), WIDTH in 2..256");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_NONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_work, w_work_nxt;
    logic             w_in_ready_nxt, w_out_valid_nxt, w_out_last_nxt, w_out_none_nxt;
    logic [IDX_W-1:0] w_out_idx_nxt;
    logic [WIDTH-1:0] w_work_clr;

    function automatic logic [IDX_W-1:0] f_prio(input logic [WIDTH-1:0] v);
        f_prio = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) if (v[i]) f_prio = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) f_prio = IDX_W'(i);
        end
    endfunction

    function automatic logic f_single(input logic [WIDTH-1:0] v);
        f_single = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

`ifdef PRIORITY_SCAN_CNT_EN
    logic [IDX_W:0] w_out_cnt_nxt;

    function automatic logic [IDX_W:0] f_popcnt(input logic [WIDTH-1:0] v);
        f_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) f_popcnt = f_popcnt + (IDX_W+1)'(v[i]);
    endfunction
`endif

    // Work vector with the currently presented bit removed.
    assign w_work_clr = r_work & ~(WIDTH'(1) << out_idx);

    // Every output is registered: the next-cycle values are computed here and
    // loaded on the edge, so nothing combinational reaches an output port.
    always_comb begin
        w_state_nxt     = r_state;
        w_work_nxt      = r_work;
        w_in_ready_nxt  = in_ready;
        w_out_valid_nxt = out_valid;
        w_out_idx_nxt   = out_idx;
        w_out_last_nxt  = out_last;
        w_out_none_nxt  = out_none;
`ifdef PRIORITY_SCAN_CNT_EN
        w_out_cnt_nxt   = out_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_in_ready_nxt = 1'b1;
                if (in_valid && in_ready) begin
                    w_work_nxt      = in_vec;
                    w_in_ready_nxt  = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    if (in_vec != '0) begin
                        w_state_nxt    = ST_SCAN;
                        w_out_idx_nxt  = f_prio(in_vec);
                        w_out_last_nxt = f_single(in_vec);
                        w_out_none_nxt = 1'b0;
`ifdef PRIORITY_SCAN_CNT_EN
                        w_out_cnt_nxt  = f_popcnt(in_vec);
`endif
                    end else begin
                        w_state_nxt    = ST_NONE;
                        w_out_idx_nxt  = '0;
                        w_out_last_nxt = 1'b1;
                        w_out_none_nxt = 1'b1;
`ifdef PRIORITY_SCAN_CNT_EN
                        w_out_cnt_nxt  = '0;
`endif
                    end
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    w_work_nxt = w_work_clr;
                    if (out_last) begin
                        w_state_nxt     = ST_IDLE;
                        w_in_ready_nxt  = 1'b1;
                        w_out_valid_nxt = 1'b0;
                        w_out_idx_nxt   = '0;
                        w_out_last_nxt  = 1'b0;
                    end else begin
                        w_out_idx_nxt  = f_prio(w_work_clr);
                        w_out_last_nxt = f_single(w_work_clr);
                    end
                end
            end
            ST_NONE: begin
                if (out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_in_ready_nxt  = 1'b1;
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_out_none_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_in_ready_nxt  = 1'b0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_work    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_none  <= 1'b0;
`ifdef PRIORITY_SCAN_CNT_EN
            out_cnt   <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_work    <= w_work_nxt;
            in_ready  <= w_in_ready_nxt;
            out_valid <= w_out_valid_nxt;
            out_idx   <= w_out_idx_nxt;
            out_last  <= w_out_last_nxt;
            out_none  <= w_out_none_nxt;
`ifdef PRIORITY_SCAN_CNT_EN
            out_cnt   <= w_out_cnt_nxt;
`endif
        end
    end

endmodule
